// File: rtl/gray_window3x3_if.sv
// Pixel-stream in / 3x3-window out bundle between the gray converter, the window
// generator and the Sobel stage.
interface gray_window3x3_if #(
    parameter int unsigned PIX_W = 8
) ();
    localparam int unsigned COL_W = 11;

    logic [PIX_W-1:0]   pix_in;
    logic               pix_valid;
    logic               sof;
    logic [9*PIX_W-1:0] window;
    logic               window_valid;
    logic [COL_W-1:0]   col_out;

    // Upstream side: produces pixels, consumes windows.
    modport master (
        output pix_in, pix_valid, sof,
        input  window, window_valid, col_out
    );

    // Window generator side.
    modport slave (
        input  pix_in, pix_valid, sof,
        output window, window_valid, col_out
    );
endinterface

// File: rtl/gray_window3x3.sv
// Line-buffered 3x3 neighbourhood generator: two line RAMs feed the right column of
// a shifting 3x3 register window; row/column position is tracked internally.
module gray_window3x3 #(
    parameter int unsigned LINE_WIDTH = 640,
    parameter int unsigned PIX_W      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    gray_window3x3_if.slave      win_if
);
    localparam int unsigned COL_W  = 11;
    localparam int unsigned ADDR_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);
    localparam logic [1:0]       ROW_FULL = 2'd2;

    typedef logic [PIX_W-1:0] pix_t;

    logic [COL_W-1:0] col_q, col_d, eff_col;
    logic [1:0]       row_q, row_d, eff_row;
    pix_t             w_q [3][3];
    pix_t             w_d [3][3];
    logic             valid_q, valid_d;
    logic [COL_W-1:0] col_out_q, col_out_d;

    pix_t             lb_top [LINE_WIDTH];
    pix_t             lb_mid [LINE_WIDTH];
    logic [ADDR_W-1:0] addr;
    pix_t             top_rd, mid_rd;
    logic [9*PIX_W-1:0] window_pack;

    // sof forces the accompanied pixel to row 0, col 0 regardless of the counters.
    always_comb begin
        eff_col = win_if.sof ? '0 : col_q;
        eff_row = win_if.sof ? '0 : row_q;
        addr    = ADDR_W'(eff_col);
        top_rd  = lb_top[addr];
        mid_rd  = lb_mid[addr];
    end

    // Next-state: window shift, position counters, output flags.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        valid_d   = valid_q;
        col_out_d = col_out_q;
        w_d       = w_q;
        if (win_if.pix_valid) begin
            for (int r = 0; r < 3; r++) begin
                w_d[r][0] = w_q[r][1];
                w_d[r][1] = w_q[r][2];
            end
            w_d[0][2] = top_rd;
            w_d[1][2] = mid_rd;
            w_d[2][2] = win_if.pix_in;

            valid_d   = (eff_row == ROW_FULL) && (eff_col >= COL_W'(2));
            col_out_d = eff_col;

            if (eff_col == LAST_COL) begin
                col_d = '0;
                row_d = (eff_row == ROW_FULL) ? ROW_FULL : eff_row + 2'd1;
            end else begin
                col_d = eff_col + COL_W'(1);
                row_d = eff_row;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
            col_out_q <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            valid_q   <= valid_d;
            col_out_q <= col_out_d;
            w_q       <= w_d;
        end
    end

    // Line RAMs: asynchronous read sees the pre-edge contents, so read-before-write
    // at the same address holds without a bypass. Contents are never cleared.
    always_ff @(posedge clock) begin
        if (reset && win_if.pix_valid) begin
            lb_top[addr] <= mid_rd;
            lb_mid[addr] <= win_if.pix_in;
        end
    end

    // Top-left lands in the most significant slot, current pixel in the least.
    always_comb begin
        window_pack = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window_pack[(8 - (r * 3 + c)) * PIX_W +: PIX_W] = w_q[r][c];
            end
        end
    end

    assign win_if.window       = window_pack;
    assign win_if.window_valid = valid_q;
    assign win_if.col_out      = col_out_q;
endmodule

// File: tb/tb_gray_window3x3.sv
// Scoreboard bench for gray_window3x3: a frame-position model predicts every cycle's
// outputs, a monitor compares them one cycle after each drive.
module tb_gray_window3x3;
    localparam int LW = 8;

    typedef struct {
        logic [71:0] win;
        logic        valid;
        logic [10:0] col;
        bit          full;
    } exp_t;

    logic clock;
    logic reset;
    int   chk_cnt = 0;
    int   err_cnt = 0;

    exp_t sbq[$];
    exp_t last_e;

    int       m_row;
    int       m_col;
    bit [7:0] pixmem[int];
    bit [7:0] hist[3];

    gray_window3x3_if #(.PIX_W(8)) bus ();

    gray_window3x3 #(.LINE_WIDTH(LW), .PIX_W(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .win_if (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle of inputs and push the outputs expected after the next edge.
    task automatic step(input bit rst, input bit v, input bit s, input logic [7:0] p);
        exp_t e;
        @(negedge clock);
        reset         = rst;
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = p;
        if (!rst) begin
            m_row = 0;
            m_col = 0;
            pixmem.delete();
            hist = '{8'h0, 8'h0, 8'h0};
            e = '{win: '0, valid: 1'b0, col: '0, full: 1'b1};
        end else if (v) begin
            if (s) begin
                m_row = 0;
                m_col = 0;
                pixmem.delete();
            end
            pixmem[m_row * 4096 + m_col] = p;
            hist[0] = hist[1];
            hist[1] = hist[2];
            hist[2] = p;
            e.col   = 11'(m_col);
            e.valid = (m_row >= 2) && (m_col >= 2);
            e.full  = e.valid;
            e.win   = '0;
            if (e.valid) begin
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        e.win[(8 - (dr * 3 + dc)) * 8 +: 8] =
                            pixmem[(m_row - 2 + dr) * 4096 + (m_col - 2 + dc)];
            end else begin
                e.win[23:0] = {hist[0], hist[1], hist[2]};
            end
            m_col++;
            if (m_col == LW) begin
                m_col = 0;
                m_row++;
            end
        end else begin
            e = last_e;
        end
        last_e = e;
        sbq.push_back(e);
    endtask

    task automatic ramp_frame(input int rows, input int gap, input int base, input bit first_sof);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < LW; c++) begin
                step(1'b1, 1'b1, first_sof && r == 0 && c == 0, 8'(base + r * 16 + c));
                repeat (gap) step(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
            end
    endtask

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] want);
        chk_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: outputs of the edge that consumed the oldest pushed drive.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("window_valid", 72'(bus.window_valid), 72'(e.valid));
                chk("col_out", 72'(bus.col_out), 72'(e.col));
                if (e.full)
                    chk("window", bus.window, e.win);
                else
                    chk("window_bottom_row", 72'(bus.window[23:0]), 72'(e.win[23:0]));
            end
        end
    end

    initial begin
        reset         = 1'b0;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_in    = '0;
        last_e        = '{win: '0, valid: 1'b0, col: '0, full: 1'b1};

        // Reset held with pixels strobed.
        repeat (3) step(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));

        // Continuous ramp frame, then the same frame gapped 1-0-0-1.
        ramp_frame(4, 0, 0, 1'b1);
        ramp_frame(4, 2, 0, 1'b1);

        // Frame A interrupted by sof at (1,5); new frame offset by 0x80.
        for (int k = 0; k < LW + 5; k++)
            step(1'b1, 1'b1, k == 0, 8'(8'h40 + (k / LW) * 16 + (k % LW)));
        ramp_frame(4, 0, 8'h80, 1'b1);

        // Reset for one cycle at (3,4), resume without sof.
        for (int k = 0; k < 3 * LW + 4; k++)
            step(1'b1, 1'b1, k == 0, 8'((k / LW) * 16 + (k % LW)));
        step(1'b0, 1'b1, 1'b0, 8'h34);
        ramp_frame(4, 0, 8'h20, 1'b0);

        // Randomised traffic: idles, stray sof, occasional reset.
        repeat (1500) begin
            step($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 59) == 0, 8'($urandom_range(0, 255)));
        end

        repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (4) @(posedge clock);
        #3;
        chk("scoreboard_drained", 72'(sbq.size()), 72'(0));
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
